// File: rtl/vdic_dut_2022.sv
// Serial frame calculator.
//
// Receives a frame of 2..9 data words followed by one command word on a
// one-bit serial input and returns a status word, plus two result words
// when the status is clean, on a one-bit serial output.
//
// Word format (both directions, MSB first, 11 bits):
//   start(0), type(0 = data, 1 = command), payload[7:0], stop(1)
//
// Ports:
//   clk        rising-edge clock for all logic
//   rst_n      synchronous reset, ACTIVE-HIGH despite the name
//   enable_n   active-low frame enable; din is only looked at while low
//   din        serial request stream
//   dout       serial response stream, 0 whenever dout_valid is low
//   dout_valid high exactly while response bits are on dout
module vdic_dut_2022 (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  // Bit index (after the start bit) at which the stop bit arrives on din.
  localparam logic [3:0] RxStopIdx = 4'd9;
  // Bit index of the stop bit within a transmitted word.
  localparam logic [3:0] TxStopIdx = 4'd10;
  // Argument count saturates here: any tenth data word is already an error.
  localparam logic [3:0] CntSat    = 4'd10;
  localparam logic [3:0] MinArgs   = 4'd2;
  localparam logic [3:0] MaxArgs   = 4'd9;

  localparam logic [7:0] OpAnd = 8'h01;
  localparam logic [7:0] OpOr  = 8'h02;
  localparam logic [7:0] OpXor = 8'h03;
  localparam logic [7:0] OpAdd = 8'h04;
  localparam logic [7:0] OpSub = 8'h05;

  localparam logic [7:0] StatusFrameErr = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StRxBit,
    StWaitEnHigh
  } rx_state_e;

  typedef enum logic [1:0] {
    StTxIdle,
    StTxStatus,
    StTxMsb,
    StTxLsb
  } tx_state_e;

  function automatic logic [10:0] make_word(input logic is_cmd, input logic [7:0] payload);
    return {1'b0, is_cmd, payload, 1'b1};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_bit_q, rx_bit_d;    // bits received since the start bit
  logic [8:0]  rx_sh_q, rx_sh_d;      // {type, payload} shift register
  logic [3:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  arg0_q, arg0_d;        // first argument, needed by SUB
  logic [7:0]  and_q, and_d;
  logic [7:0]  or_q, or_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] sum_q, sum_d;          // sum of all arguments, mod 2^16

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [10:0] tx_sh_q, tx_sh_d;      // word being sent, MSB on dout
  logic [15:0] result_q, result_d;
  logic        tx_ok_q, tx_ok_d;      // status was clean: result words follow

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic       tx_busy;
  logic       frame_err;   // stop bit of 0 seen this cycle
  logic       cmd_done;    // command word completed this cycle
  logic       clear_frame;
  logic       word_is_cmd;
  logic [7:0] word_payload;

  assign tx_busy      = (tx_state_q != StTxIdle);
  assign word_is_cmd  = rx_sh_q[8];
  assign word_payload = rx_sh_q[7:0];

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    arg_cnt_d   = arg_cnt_q;
    arg0_d      = arg0_q;
    and_d       = and_q;
    or_d        = or_q;
    xor_d       = xor_q;
    sum_d       = sum_q;
    frame_err   = 1'b0;
    cmd_done    = 1'b0;
    clear_frame = 1'b0;

    unique case (rx_state_q)
      StIdle: begin
        if (enable_n) begin
          // Enable dropped between words: any partial frame is discarded.
          clear_frame = 1'b1;
        end else if (!din && !tx_busy) begin
          rx_state_d = StRxBit;
          rx_bit_d   = '0;
        end
      end

      StRxBit: begin
        if (enable_n) begin
          rx_state_d  = StIdle;
          clear_frame = 1'b1;
        end else if (rx_bit_q == RxStopIdx) begin
          rx_bit_d = '0;
          if (!din) begin
            frame_err   = 1'b1;
            rx_state_d  = StWaitEnHigh;
            clear_frame = 1'b1;
          end else if (word_is_cmd) begin
            cmd_done    = 1'b1;
            rx_state_d  = StIdle;
            clear_frame = 1'b1;
          end else begin
            rx_state_d = StIdle;
            if (arg_cnt_q == '0) begin
              arg0_d = word_payload;
              and_d  = word_payload;
              or_d   = word_payload;
              xor_d  = word_payload;
              sum_d  = {8'h00, word_payload};
            end else begin
              and_d = and_q & word_payload;
              or_d  = or_q | word_payload;
              xor_d = xor_q ^ word_payload;
              sum_d = sum_q + {8'h00, word_payload};
            end
            if (arg_cnt_q != CntSat) begin
              arg_cnt_d = arg_cnt_q + 4'd1;
            end
          end
        end else begin
          rx_sh_d  = {rx_sh_q[7:0], din};
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end

      StWaitEnHigh: begin
        if (enable_n) begin
          rx_state_d = StIdle;
        end
      end

      default: rx_state_d = StIdle;
    endcase

    if (clear_frame) begin
      arg_cnt_d = '0;
      arg0_d    = '0;
      and_d     = '0;
      or_d      = '0;
      xor_d     = '0;
      sum_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode: evaluated against the accumulators as they stand when the
  // command word completes.
  // ---------------------------------------------------------------------------
  logic        err_cnt;
  logic        err_cmd;
  logic [15:0] op_result;
  logic [7:0]  status;

  always_comb begin
    err_cnt   = (arg_cnt_q < MinArgs) || (arg_cnt_q > MaxArgs);
    err_cmd   = 1'b0;
    op_result = '0;
    unique case (word_payload)
      OpAnd:   op_result = {8'h00, and_q};
      OpOr:    op_result = {8'h00, or_q};
      OpXor:   op_result = {8'h00, xor_q};
      OpAdd:   op_result = sum_q;
      // arg0 - (sum - arg0) == 2*arg0 - sum
      OpSub:   op_result = {7'b0, arg0_q, 1'b0} - sum_q;
      default: err_cmd   = 1'b1;
    endcase

    if (frame_err) begin
      status = StatusFrameErr;
    end else begin
      status = {5'b0, err_cnt, err_cmd, 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic tx_word_end;

  assign tx_word_end = (tx_bit_q == TxStopIdx);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    result_d   = result_q;
    tx_ok_d    = tx_ok_q;

    if (tx_busy && !tx_word_end) begin
      tx_sh_d  = {tx_sh_q[9:0], 1'b0};
      tx_bit_d = tx_bit_q + 4'd1;
    end

    unique case (tx_state_q)
      StTxIdle: begin
        // Load in the same edge that samples the final stop bit so the
        // response start bit follows on the very next cycle.
        if (frame_err || cmd_done) begin
          tx_state_d = StTxStatus;
          tx_bit_d   = '0;
          tx_sh_d    = make_word(1'b1, status);
          result_d   = op_result;
          tx_ok_d    = (status == 8'h00);
        end
      end

      StTxStatus: begin
        if (tx_word_end) begin
          tx_bit_d = '0;
          if (tx_ok_q) begin
            tx_state_d = StTxMsb;
            tx_sh_d    = make_word(1'b0, result_q[15:8]);
          end else begin
            tx_state_d = StTxIdle;
            tx_sh_d    = '0;
          end
        end
      end

      StTxMsb: begin
        if (tx_word_end) begin
          tx_state_d = StTxLsb;
          tx_bit_d   = '0;
          tx_sh_d    = make_word(1'b0, result_q[7:0]);
        end
      end

      StTxLsb: begin
        if (tx_word_end) begin
          tx_state_d = StTxIdle;
          tx_bit_d   = '0;
          tx_sh_d    = '0;
        end
      end

      default: tx_state_d = StTxIdle;
    endcase
  end

  assign dout_valid = tx_busy;
  assign dout       = tx_busy & tx_sh_q[10];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_state_q <= StIdle;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      arg_cnt_q  <= '0;
      arg0_q     <= '0;
      and_q      <= '0;
      or_q       <= '0;
      xor_q      <= '0;
      sum_q      <= '0;
      tx_state_q <= StTxIdle;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      result_q   <= '0;
      tx_ok_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      arg_cnt_q  <= arg_cnt_d;
      arg0_q     <= arg0_d;
      and_q      <= and_d;
      or_q       <= or_d;
      xor_q      <= xor_d;
      sum_q      <= sum_d;
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      result_q   <= result_d;
      tx_ok_q    <= tx_ok_d;
    end
  end

endmodule

// File: tb/tb_vdic_dut_2022.sv
// Directed testbench for vdic_dut_2022. Inputs are driven and outputs sampled
// on the falling clock edge; all tasks start and end on a falling edge.
module tb_vdic_dut_2022;

  logic clk = 1'b0;
  logic rst_n;
  logic enable_n;
  logic din;
  logic dout;
  logic dout_valid;

  always #5 clk = ~clk;

  vdic_dut_2022 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] data_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] word(input logic is_cmd, input logic [7:0] payload);
    return {1'b0, is_cmd, payload, 1'b1};
  endfunction

  task automatic send_word(input logic is_cmd, input logic [7:0] payload, input logic stop);
    logic [10:0] w;
    w = {1'b0, is_cmd, payload, stop};
    for (int i = 10; i >= 0; i--) begin
      enable_n = 1'b0;
      din      = w[i];
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd);
    foreach (data_q[i]) send_word(1'b0, data_q[i], 1'b1);
    send_word(1'b1, cmd, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enable_n = 1'b1;
      din      = 1'b1;
      @(negedge clk);
    end
  endtask

  // Enable held low with line idle (1s between words).
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      enable_n = 1'b0;
      din      = 1'b1;
      @(negedge clk);
    end
  endtask

  // Collect the response; din carries noise meanwhile, which must be ignored.
  task automatic get_resp(input string tag, output int nv, output logic [32:0] bits);
    nv   = 0;
    bits = '0;
    for (int i = 0; i < 40; i++) begin
      if (!dout_valid) break;
      bits     = {bits[31:0], dout};
      nv++;
      enable_n = 1'b0;
      din      = i[0];
      @(negedge clk);
    end
    din = 1'b1;
    check_eq({tag, "_idle_dout"}, 64'(dout), 64'd0);
  endtask

  task automatic expect_ok(input string tag, input logic [15:0] res);
    int          nv;
    logic [32:0] bits;
    get_resp(tag, nv, bits);
    check_eq({tag, "_len"}, 64'(nv), 64'd33);
    check_eq({tag, "_words"}, 64'(bits),
             64'({word(1'b1, 8'h00), word(1'b0, res[15:8]), word(1'b0, res[7:0])}));
  endtask

  task automatic expect_err(input string tag, input logic [7:0] st);
    int          nv;
    logic [32:0] bits;
    get_resp(tag, nv, bits);
    check_eq({tag, "_len"}, 64'(nv), 64'd11);
    check_eq({tag, "_words"}, 64'(bits), 64'({22'b0, word(1'b1, st)}));
  endtask

  initial begin
    logic [10:0] pw;
    rst_n    = 1'b1;
    enable_n = 1'b1;
    din      = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", 64'(dout_valid), 64'd0);
    check_eq("rst_dout", 64'(dout), 64'd0);

    // Frame begins on the first cycle after reset deasserts.
    rst_n  = 1'b0;
    data_q = '{8'h0F, 8'hF3};
    send_frame(8'h01);
    expect_ok("and", 16'h0003);
    idle(2);

    // Nine 0xFF with idle 1s inside the frame: 9*255 = 0x08F7.
    for (int i = 0; i < 9; i++) begin
      send_word(1'b0, 8'hFF, 1'b1);
      if (i == 4) gap(3);
    end
    send_word(1'b1, 8'h04, 1'b1);
    expect_ok("add9", 16'h08F7);
    idle(2);

    data_q = '{8'h01, 8'h02};
    send_frame(8'h05);
    expect_ok("sub_wrap", 16'hFFFF);
    idle(2);

    data_q = '{8'hA5, 8'h3C};
    send_frame(8'h02);
    expect_ok("or", 16'h00BD);
    idle(2);
    send_frame(8'h03);
    expect_ok("xor", 16'h0099);
    idle(2);

    data_q = '{8'h10, 8'h20};
    send_frame(8'h7E);
    expect_err("bad_cmd", 8'h02);
    idle(2);

    data_q = '{8'h55};
    send_frame(8'h02);
    expect_err("one_arg", 8'h04);
    idle(2);

    // Ten data words: count error reported at the command.
    for (int i = 0; i < 10; i++) send_word(1'b0, 8'h01, 1'b1);
    send_word(1'b1, 8'h04, 1'b1);
    expect_err("ten_args", 8'h04);
    idle(2);

    // Stop bit 0 in second data word, then a full frame while enable stays low.
    send_word(1'b0, 8'h11, 1'b1);
    send_word(1'b0, 8'h22, 1'b0);
    expect_err("frame_err", 8'h01);
    data_q = '{8'h0F, 8'hF3};
    send_frame(8'h01);
    check_eq("wait_en_ignore", 64'(dout_valid), 64'd0);
    idle(2);

    // Enable rising between words discards the data words.
    send_word(1'b0, 8'hAA, 1'b1);
    send_word(1'b0, 8'hBB, 1'b1);
    idle(2);
    send_word(1'b1, 8'h04, 1'b1);
    expect_err("discard_words", 8'h04);
    idle(2);

    // Enable rising mid command word: no response at all.
    send_word(1'b0, 8'h33, 1'b1);
    send_word(1'b0, 8'h44, 1'b1);
    pw = word(1'b1, 8'h04);
    for (int i = 10; i > 5; i--) begin
      enable_n = 1'b0;
      din      = pw[i];
      @(negedge clk);
    end
    idle(3);
    check_eq("discard_partial", 64'(dout_valid), 64'd0);
    data_q = '{8'h07, 8'h08};
    send_frame(8'h04);
    expect_ok("after_discard", 16'h000F);
    idle(2);

    // Reset during the result MSB word.
    data_q = '{8'h0F, 8'hF3};
    send_frame(8'h01);
    for (int i = 0; i < 13; i++) begin
      din = 1'b1;
      @(negedge clk);
    end
    check_eq("pre_rst_valid", 64'(dout_valid), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(dout_valid), 64'd0);
    check_eq("mid_rst_dout", 64'(dout), 64'd0);
    rst_n  = 1'b0;
    data_q = '{8'h01, 8'h02};
    send_frame(8'h04);
    expect_ok("post_rst_add", 16'h0003);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
